// File: rtl/uio_bus_pkg.sv
// Shared types and constants for the uio pad-bus scheduler.
package uio_bus_pkg;

  localparam int BUS_W = 8;

  localparam logic [BUS_W-1:0] OE_DRIVE   = 8'hFF;
  localparam logic [BUS_W-1:0] OE_RELEASE = 8'h00;

  // Scheduler FSM states. IDLE is the only state in which a grant can be issued.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TURN   = 2'd1,
    ST_DRIVE  = 2'd2,
    ST_SAMPLE = 2'd3
  } state_t;

  // Larger of two integers, used to size the shared phase counter.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uio_bus_sched_rr_arbiter.sv
// Combinational round-robin arbiter. Searches upward from the slot after
// i_ptr (wrapping) and grants the first active request. The pointer register
// itself lives in the caller so the caller decides when it advances.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx
);

  int   w_j;
  logic w_found;

  // Priority search starting just after the last winner.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_j = (int'(i_ptr) + k) % NUM_REQ;
      if (i_en && !w_found && i_req[w_j]) begin
        o_gnt[w_j] = 1'b1;
        o_idx      = IDX_W'(w_j);
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uio_bus_sched.sv
// Scheduler for the shared 8-bit bidirectional uio pad bus. Requesters issue
// single-byte write (drive) or read (sample) beats; beats are granted
// round-robin, a turnaround gap is inserted on every direction change, each
// beat holds the bus for HOLD cycles, and reads return a one-cycle response.
//
// Handshake: a requester raises req_valid with req_write/req_wdata stable and
// keeps them stable until it sees req_ready; the beat transfers in the cycle
// where req_valid & req_ready are both high. req_ready is one-hot, only ever
// high in IDLE with ena=1 and reset released. Dropping req_valid before a
// grant is allowed and simply withdraws the request.
module uio_bus_sched
  import uio_bus_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int TURNAROUND = 1,
  parameter int HOLD       = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*8-1:0]         req_wdata,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [7:0]                   rsp_rdata,
  input  logic [7:0]                   uio_in,
  output logic [7:0]                   uio_out,
  output logic [7:0]                   uio_oe,
  output logic                         busy
);

  localparam int IDW     = $clog2(NUM_REQ);
  localparam int CNT_MAX = max2(HOLD, TURNAROUND);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Counter reload values: the counter runs down to zero, so a phase of N
  // cycles is loaded with N-1 on entry.
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] TURN_LD = CNT_W'(TURNAROUND - 1);

  state_t               r_state;
  logic                 r_dir;        // current bus direction: 1=write, 0=read
  logic [IDW-1:0]       r_ptr;        // last winner, round-robin starts after it
  logic                 r_wr;         // latched beat direction
  logic [BUS_W-1:0]     r_wdata;      // latched write byte
  logic [IDW-1:0]       r_id;         // latched owner of the beat
  logic [CNT_W-1:0]     r_cnt;
  logic [BUS_W-1:0]     r_oe;
  logic [BUS_W-1:0]     r_out;
  logic                 r_rsp_valid;
  logic [IDW-1:0]       r_rsp_id;
  logic [BUS_W-1:0]     r_rsp_rdata;

  logic                 w_arb_en;
  logic [NUM_REQ-1:0]   w_gnt;
  logic [IDW-1:0]       w_idx;
  logic                 w_accept;
  logic                 w_sel_write;
  logic [BUS_W-1:0]     w_sel_wdata;

  // Grants only in IDLE with ena high; reset also blocks the handshake so no
  // requester believes a beat was taken while the block is held in reset.
  assign w_arb_en = rst_n && ena && (r_state == ST_IDLE);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDW)
  ) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .i_en  (w_arb_en),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign w_accept = |w_gnt;

  // Select the winning requester's direction and write byte.
  always_comb begin
    w_sel_write = 1'b0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_write = req_write[i];
        w_sel_wdata = req_wdata[i*8 +: 8];
      end
    end
  end

  // Scheduler FSM with registered pad and response outputs. Pad outputs are
  // loaded on the transition into each state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_dir       <= 1'b0;
      r_ptr       <= IDW'(NUM_REQ - 1);
      r_wr        <= 1'b0;
      r_wdata     <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_oe        <= OE_RELEASE;
      r_out       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Bus stays parked (oe follows r_dir, uio_out unchanged) until a grant.
          if (w_accept) begin
            r_wr    <= w_sel_write;
            r_wdata <= w_sel_wdata;
            r_id    <= w_idx;
            r_ptr   <= w_idx;
            if (w_sel_write != r_dir) begin
              r_state <= ST_TURN;
              r_cnt   <= TURN_LD;
              r_oe    <= OE_RELEASE;
            end else if (w_sel_write) begin
              r_state <= ST_DRIVE;
              r_cnt   <= HOLD_LD;
              r_oe    <= OE_DRIVE;
              r_out   <= w_sel_wdata;
            end else begin
              r_state <= ST_SAMPLE;
              r_cnt   <= HOLD_LD;
              r_oe    <= OE_RELEASE;
            end
          end
        end
        ST_TURN: begin
          if (r_cnt == '0) begin
            r_dir <= r_wr;
            r_cnt <= HOLD_LD;
            if (r_wr) begin
              r_state <= ST_DRIVE;
              r_oe    <= OE_DRIVE;
              r_out   <= r_wdata;
            end else begin
              r_state <= ST_SAMPLE;
              r_oe    <= OE_RELEASE;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DRIVE: begin
          // Leaving DRIVE keeps oe asserted: the bus parks in write direction.
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_SAMPLE: begin
          // The edge ending the last SAMPLE cycle captures the pad byte.
          if (r_cnt == '0) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_rdata <= uio_in;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = w_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_rdata = r_rsp_rdata;
  assign uio_out   = r_out;
  assign uio_oe    = r_oe;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: doc/uio_bus_sched.md
Name: uio_bus_sched

Overview:
- Schedules the shared 8-bit bidirectional uio pad bus (uio_in/uio_out/uio_oe) of the tt_um top between NUM_REQ internal requesters.
- Each requester issues single-byte write (drive) or read (sample) beats through a valid/ready handshake.
- The block arbitrates round-robin, inserts bus-turnaround cycles on direction change, holds each beat for HOLD cycles and returns read data with a one-cycle response pulse.
- Sits directly between the project core logic and the uio pins.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- TURNAROUND, 1, idle cycles with uio_oe=00 inserted on a direction change (1..3)
- HOLD, 2, cycles each beat occupies the bus (1..4)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  design enable; gates new grants only
- req_valid  in  NUM_REQ  per-requester beat request
- req_write  in  NUM_REQ  1=write beat, 0=read beat
- req_wdata  in  NUM_REQ*8  write byte, requester i at bits [8i+7:8i]
- req_ready  out  NUM_REQ  one-hot accept; a beat transfers when valid&ready
- rsp_valid  out  1  one-cycle read-data pulse
- rsp_id  out  $clog2(NUM_REQ)  requester owning rsp_rdata
- rsp_rdata  out  8  sampled read byte
- uio_in  in  8  pad input path
- uio_out  out  8  pad output path (registered)
- uio_oe  out  8  pad enable, 8'hFF drive / 8'h00 release (registered)
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, immediate):
  - state=IDLE, dir_q=0 (read), rr_ptr=NUM_REQ-1 so requester 0 wins first.
  - uio_oe=00, uio_out=00, rsp_valid=0, rsp_id=0, rsp_rdata=00, busy=0.
- States: IDLE, TURN, DRIVE, SAMPLE.
- IDLE:
  - If ena=1 and any req_valid: the round-robin winner (first valid after rr_ptr, wrapping) gets req_ready=1 combinationally in this cycle.
  - Latch write flag, wdata and id; rr_ptr <= winner.
  - req_ready is 0 in every other state and whenever ena=0.
  - Next state is TURN if the latched write flag != dir_q, else DRIVE (write) or SAMPLE (read).
- TURN: uio_oe=00 for exactly TURNAROUND cycles; then dir_q <= latched flag and go to DRIVE or SAMPLE.
- DRIVE: uio_oe=FF, uio_out=latched wdata for HOLD cycles, then IDLE.
- SAMPLE:
  - uio_oe=00 for HOLD cycles.
  - uio_in is captured at the clock edge ending the last SAMPLE cycle.
  - rsp_valid=1, rsp_id and rsp_rdata are valid in the following cycle (the first IDLE cycle), for one cycle only.
- Parked bus: in IDLE, uio_oe follows dir_q (FF after writes, 00 after reads) and uio_out holds its last value. No turnaround between consecutive same-direction beats.
- Latency:
  - Same-direction beat: accept at T, bus active T+1..T+HOLD, next accept at T+HOLD+1.
  - Direction change: add TURNAROUND cycles.
  - Read response: T+HOLD+1 (+TURNAROUND if turning).
- ena:
  - Deassert mid-beat: the beat (including TURN) completes normally.
  - Deassert in IDLE: no grant; pending valids wait, and the bus stays parked.
- Requesters must hold req_valid/req_write/req_wdata stable until ready. Deasserting valid without a grant is legal and is ignored.
- Single requester: it is re-granted every IDLE while valid.
- Reset mid-beat: the beat is aborted, uio_oe drops to 00 asynchronously, and no rsp_valid is issued.
- Counter width: $clog2 of max(HOLD, TURNAROUND)+1; the counter reloads on each state entry.

Decomposition:
- Package uio_bus_pkg: state enum (IDLE, TURN, DRIVE, SAMPLE), BUS_W=8, OE_DRIVE=8'hFF, OE_RELEASE=8'h00.
- Sub-module rr_arbiter (NUM_REQ): inputs req vector, pointer and enable; outputs one-hot grant and encoded index. It is purely combinational. The pointer register stays in uio_bus_sched.

Test Plan (NUM_REQ=4, TURNAROUND=1, HOLD=2):
1. Reset:
   - Stimulus: assert rst_n=0 mid-clock.
   - Response: uio_oe=00, uio_out=00, rsp_valid=0, req_ready=0000, busy=0 without waiting for a clk edge.
2. First write:
   - Stimulus: requester 1 write A5 at T.
   - Response: req_ready=0010 at T; T+1 uio_oe=00 (TURN); T+2..T+3 uio_oe=FF, uio_out=A5; T+4 IDLE with uio_oe still FF.
3. Read after write:
   - Stimulus: requester 2 read at T, uio_in=3C.
   - Response: T+1 uio_oe=00; SAMPLE T+2..T+3; T+4 rsp_valid=1, rsp_id=2, rsp_rdata=3C; T+5 rsp_valid=0.
4. Round-robin fairness:
   - Stimulus: all four requesters hold write valid continuously, starting from dir_q=write.
   - Response: grants in order 0,1,2,3,0 every 3 cycles; no TURN cycles.
5. Enable gating:
   - Stimulus: ena=0 with requester 3 valid.
   - Response: no req_ready for 10 cycles. After ena=1, granted in the next IDLE cycle. Dropping ena during DRIVE still completes both HOLD cycles.
6. Reset during DRIVE:
   - Stimulus: rst_n=0 in the 1st DRIVE cycle.
   - Response: uio_oe=00 immediately; no further uio_out drive. After release, a write from requester 0 incurs TURN again.
